aes_sbox_arbiter: RTL and testbench

- Shares one 32-bit S-box lane (four byte S-boxes, combinational, outside this block) between two requesters.
- Requester A is the round datapath: full 128-bit SubBytes, sequenced as 4 word beats.
- Requester K is key expansion: 32-bit SubWord, 1 beat.
- Sits between the round controller, the key-schedule unit and the shared S-box lane; replaces a dedicated 128-bit SubBytes instance to save area.

---
 rtl/aes_sbox_arbiter.sv | 112 +++++++++++
 tb/tb_aes_sbox_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_arbiter.sv
// Time-shares one external 32-bit S-box lane between a 4-beat state SubBytes
// requester (A) and a single-beat key-expansion SubWord requester (K).
module aes_sbox_arbiter #(
    parameter bit KEY_PRIORITY = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_req,
    input  logic [127:0] a_data,
    output logic         a_ack,
    output logic [127:0] a_result,
    input  logic         k_req,
    input  logic [31:0]  k_word,
    output logic         k_ack,
    output logic [31:0]  k_result,
    output logic [31:0]  sbox_in,
    input  logic [31:0]  sbox_out,
    output logic         busy,
    output logic         grant_k
);

    typedef enum logic [1:0] {StIdle, StABusy, StKBusy} state_e;

    state_e       state_q;
    logic [1:0]   beat_q;
    logic         last_k_q;
    logic         a_ack_q;
    logic         k_ack_q;
    logic [127:0] a_result_q;
    logic [31:0]  k_result_q;

    logic a_elig;
    logic k_elig;
    logic pick_k;
    logic pick_a;

    // A request still high in its own ack cycle is stale and must not be re-granted.
    assign a_elig = a_req && !a_ack_q;
    assign k_elig = k_req && !k_ack_q;
    assign pick_k = k_elig && (!a_elig || KEY_PRIORITY || !last_k_q);
    assign pick_a = a_elig && !pick_k;

    always_comb begin
        sbox_in = 32'h0;
        case (state_q)
            StABusy: begin
                case (beat_q)
                    2'd0:    sbox_in = a_data[127:96];
                    2'd1:    sbox_in = a_data[95:64];
                    2'd2:    sbox_in = a_data[63:32];
                    default: sbox_in = a_data[31:0];
                endcase
            end
            StKBusy: sbox_in = k_word;
            default: sbox_in = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            beat_q     <= 2'd0;
            last_k_q   <= 1'b1;
            a_ack_q    <= 1'b0;
            k_ack_q    <= 1'b0;
            a_result_q <= 128'h0;
            k_result_q <= 32'h0;
        end else begin
            a_ack_q <= 1'b0;
            k_ack_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick_k) begin
                        state_q  <= StKBusy;
                        last_k_q <= 1'b1;
                    end else if (pick_a) begin
                        state_q  <= StABusy;
                        beat_q   <= 2'd0;
                        last_k_q <= 1'b0;
                    end
                end
                StABusy: begin
                    case (beat_q)
                        2'd0:    a_result_q[127:96] <= sbox_out;
                        2'd1:    a_result_q[95:64]  <= sbox_out;
                        2'd2:    a_result_q[63:32]  <= sbox_out;
                        default: a_result_q[31:0]   <= sbox_out;
                    endcase
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_q <= StIdle;
                        a_ack_q <= 1'b1;
                    end
                end
                StKBusy: begin
                    k_result_q <= sbox_out;
                    k_ack_q    <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign a_ack    = a_ack_q;
    assign k_ack    = k_ack_q;
    assign a_result = a_result_q;
    assign k_result = k_result_q;
    assign busy     = (state_q != StIdle);
    assign grant_k  = (state_q == StKBusy);

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Randomised bench for aes_sbox_arbiter: a reference AES S-box drives the lane and
// expected results/ack timing come from a transaction-level schedule model.
module tb_aes_sbox_arbiter;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[31-8*i -: 8] = SBOX[w[31-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance with round-robin arbitration.
    logic         a_req, k_req, a_ack, k_ack, busy, grant_k;
    logic [127:0] a_data, a_result;
    logic [31:0]  k_word, k_result, sbox_in, sbox_out;
    // Instance with key priority.
    logic         p_a_req, p_k_req, p_a_ack, p_k_ack, p_busy, p_grant_k;
    logic [127:0] p_a_data, p_a_result;
    logic [31:0]  p_k_word, p_k_result, p_sbox_in, p_sbox_out;

    assign sbox_out   = sub_word(sbox_in);
    assign p_sbox_out = sub_word(p_sbox_in);

    aes_sbox_arbiter #(.KEY_PRIORITY(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_data(a_data), .a_ack(a_ack), .a_result(a_result),
        .k_req(k_req), .k_word(k_word), .k_ack(k_ack), .k_result(k_result),
        .sbox_in(sbox_in), .sbox_out(sbox_out), .busy(busy), .grant_k(grant_k)
    );

    aes_sbox_arbiter #(.KEY_PRIORITY(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .a_req(p_a_req), .a_data(p_a_data), .a_ack(p_a_ack), .a_result(p_a_result),
        .k_req(p_k_req), .k_word(p_k_word), .k_ack(p_k_ack), .k_result(p_k_result),
        .sbox_in(p_sbox_in), .sbox_out(p_sbox_out), .busy(p_busy), .grant_k(p_grant_k)
    );

    int checks = 0;
    int errors = 0;
    int cyc;
    bit model_last_k;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_req = 1'b0; k_req = 1'b0; a_data = '0; k_word = '0;
        p_a_req = 1'b0; p_k_req = 1'b0; p_a_data = '0; p_k_word = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        model_last_k = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({a_ack, k_ack, busy, grant_k} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000", {a_ack, k_ack, busy, grant_k});
        end
        checks++;
        if (a_result !== 128'h0 || k_result !== 32'h0) begin
            errors++; $display("FAIL reset_results: got %h/%h want 0/0", a_result, k_result);
        end
        checks++;
        if (sbox_in !== 32'h0 || p_sbox_in !== 32'h0) begin
            errors++; $display("FAIL reset_sbox_in: got %h/%h want 0/0", sbox_in, p_sbox_in);
        end
        checks++;
        if ({p_a_ack, p_k_ack, p_busy, p_grant_k} !== 4'b0 || p_a_result !== '0 || p_k_result !== '0) begin
            errors++; $display("FAIL reset_prio_inst: outputs not all zero");
        end
        do_reset();
    endtask

    task automatic test_a_alone(input logic [127:0] d);
        int ack_cyc = -1, busy_n = 0, acks = 0, beat_bad = 0;
        a_data = d; a_req = 1'b1; cyc = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy) begin
                if (busy_n < 4 && sbox_in !== d[127-32*busy_n -: 32]) beat_bad++;
                busy_n++;
            end
            if (a_ack) begin
                acks++;
                if (ack_cyc < 0) ack_cyc = cyc;
                a_req = 1'b0;
            end
        end
        model_last_k = 1'b0;
        checks++;
        if (ack_cyc != 5) begin errors++; $display("FAIL a_ack_latency: got %0d want 5", ack_cyc); end
        checks++;
        if (busy_n != 4) begin errors++; $display("FAIL a_busy_cycles: got %0d want 4", busy_n); end
        checks++;
        if (acks != 1) begin errors++; $display("FAIL a_ack_pulses: got %0d want 1", acks); end
        checks++;
        if (beat_bad != 0) begin errors++; $display("FAIL a_beat_words: got %0d bad beats want 0", beat_bad); end
        checks++;
        if (a_result !== sub_state(d)) begin
            errors++; $display("FAIL a_result: got %h want %h", a_result, sub_state(d));
        end
    endtask

    task automatic test_k_alone(input logic [31:0] w);
        int ack_cyc = -1, gk_n = 0, acks = 0;
        k_word = w; k_req = 1'b1; cyc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (grant_k) gk_n++;
            if (k_ack) begin
                acks++;
                if (ack_cyc < 0) ack_cyc = cyc;
                k_req = 1'b0;
            end
        end
        model_last_k = 1'b1;
        checks++;
        if (ack_cyc != 2) begin errors++; $display("FAIL k_ack_latency: got %0d want 2", ack_cyc); end
        checks++;
        if (gk_n != 1 || acks != 1) begin
            errors++; $display("FAIL k_grant_pulses: got grant %0d ack %0d want 1 1", gk_n, acks);
        end
        checks++;
        if (k_result !== sub_word(w)) begin
            errors++; $display("FAIL k_result: got %h want %h", k_result, sub_word(w));
        end
    endtask

    task automatic test_simul_rr(input string name);
        logic [127:0] d = rand128();
        logic [31:0]  w = $urandom;
        bit first_k = !model_last_k;
        int exp_a = first_k ? 7 : 5;
        int exp_k = first_k ? 2 : 7;
        int a_c = -1, k_c = -1, both = 0;
        a_data = d; k_word = w; a_req = 1'b1; k_req = 1'b1; cyc = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (a_ack && k_ack) both++;
            if (a_ack && a_c < 0) begin a_c = cyc; a_req = 1'b0; end
            if (k_ack && k_c < 0) begin k_c = cyc; k_req = 1'b0; end
        end
        model_last_k = !first_k;
        checks++;
        if (a_c != exp_a || k_c != exp_k) begin
            errors++; $display("FAIL %s_order: got a@%0d k@%0d want a@%0d k@%0d", name, a_c, k_c, exp_a, exp_k);
        end
        checks++;
        if (both != 0) begin errors++; $display("FAIL %s_ack_overlap: got %0d want 0", name, both); end
        checks++;
        if (a_result !== sub_state(d) || k_result !== sub_word(w)) begin
            errors++; $display("FAIL %s_results: got %h/%h want %h/%h", name, a_result, k_result, sub_state(d), sub_word(w));
        end
    endtask

    task automatic test_key_priority();
        for (int r = 0; r < 3; r++) begin
            logic [127:0] d = rand128();
            logic [31:0]  w = $urandom;
            int a_c = -1, k_c = -1;
            p_a_data = d; p_k_word = w; p_a_req = 1'b1; p_k_req = 1'b1; cyc = 0;
            for (int i = 0; i < 14; i++) begin
                tick();
                if (p_a_ack && a_c < 0) begin a_c = cyc; p_a_req = 1'b0; end
                if (p_k_ack && k_c < 0) begin k_c = cyc; p_k_req = 1'b0; end
            end
            checks++;
            if (a_c != 7 || k_c != 2) begin
                errors++; $display("FAIL prio_order_r%0d: got a@%0d k@%0d want a@7 k@2", r, a_c, k_c);
            end
            checks++;
            if (p_a_result !== sub_state(d) || p_k_result !== sub_word(w)) begin
                errors++; $display("FAIL prio_results_r%0d: got %h/%h want %h/%h", r, p_a_result, p_k_result, sub_state(d), sub_word(w));
            end
        end
    endtask

    task automatic test_k_during_a();
        logic [127:0] d = rand128();
        logic [31:0]  w = $urandom;
        int a_c = -1, k_c = -1, held_bad = 0;
        a_data = d; k_word = w; a_req = 1'b1; k_req = 1'b0; cyc = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cyc == 2) k_req = 1'b1;
            if (a_c > 0 && a_result !== sub_state(d)) held_bad++;
            if (a_ack && a_c < 0) begin a_c = cyc; a_req = 1'b0; end
            if (k_ack && k_c < 0) begin k_c = cyc; k_req = 1'b0; end
        end
        model_last_k = 1'b1;
        checks++;
        if (a_c != 5 || k_c != 7) begin
            errors++; $display("FAIL kda_timing: got a@%0d k@%0d want a@5 k@7", a_c, k_c);
        end
        checks++;
        if (a_result !== sub_state(d) || held_bad != 0) begin
            errors++; $display("FAIL kda_a_result: got %h (%0d bad cycles) want %h", a_result, held_bad, sub_state(d));
        end
        checks++;
        if (k_result !== sub_word(w)) begin
            errors++; $display("FAIL kda_k_result: got %h want %h", k_result, sub_word(w));
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] d = rand128();
        int a_c = -1, regrant = 0;
        a_data = d; a_req = 1'b1; cyc = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (a_c > 0 && busy) regrant++;
            if (a_c > 0) a_req = 1'b0;
            if (a_ack && a_c < 0) a_c = cyc;
        end
        checks++;
        if (a_c != 5 || regrant != 0) begin
            errors++; $display("FAIL b2b_no_regrant: got ack@%0d busy-after-ack %0d want ack@5 busy 0", a_c, regrant);
        end
        test_a_alone(rand128());
    endtask

    task automatic test_reset_mid();
        int late_acks = 0;
        a_data = rand128(); a_req = 1'b1; cyc = 0;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        a_req = 1'b0;
        checks++;
        if ({a_ack, busy, grant_k} !== 3'b0 || sbox_in !== 32'h0) begin
            errors++; $display("FAIL rst_mid_ctrl: got ack/busy/gk %b sbox_in %h want 000 0", {a_ack, busy, grant_k}, sbox_in);
        end
        checks++;
        if (a_result !== 128'h0) begin
            errors++; $display("FAIL rst_mid_a_result: got %h want 0", a_result);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_last_k = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_ack || busy) late_acks++;
        end
        checks++;
        if (late_acks != 0) begin errors++; $display("FAIL rst_mid_no_ack: got %0d active cycles want 0", late_acks); end
        test_a_alone(rand128());
    endtask

    initial begin
        do_reset();
        test_reset();
        test_a_alone(128'h000102030405060708090a0b0c0d0e0f);
        checks++;
        if (a_result !== 128'h637c777bf26b6fc53001672bfed7ab76) begin
            errors++; $display("FAIL a_known_vector: got %h want 637c777bf26b6fc53001672bfed7ab76", a_result);
        end
        for (int i = 0; i < 4; i++) test_a_alone(rand128());
        test_k_alone(32'h09cf4f3c);
        checks++;
        if (k_result !== 32'h018a84eb) begin
            errors++; $display("FAIL k_known_vector: got %h want 018a84eb", k_result);
        end
        for (int i = 0; i < 4; i++) test_k_alone($urandom);
        do_reset();
        test_simul_rr("rr_after_reset");
        test_simul_rr("rr_repeat");
        test_a_alone(rand128());
        test_simul_rr("rr_after_a");
        test_key_priority();
        test_k_during_a();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
